// File: rtl/traffic_pkg.sv
// Shared phase codes, default timing and the legal phase order for the traffic-light
// sequencer and its lamp monitor.
package traffic_pkg;

    localparam logic [1:0] PH_OFF    = 2'b00;
    localparam logic [1:0] PH_RED    = 2'b01;
    localparam logic [1:0] PH_GREEN  = 2'b10;
    localparam logic [1:0] PH_YELLOW = 2'b11;

    localparam int unsigned T_RED    = 625000000;
    localparam int unsigned T_GREEN  = 625000000;
    localparam int unsigned T_YELLOW = 375000000;
    localparam int unsigned T_TOL    = 2;
    localparam int unsigned CNT_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_OFF    = 2'b00,
        ST_RED    = 2'b01,
        ST_GREEN  = 2'b10,
        ST_YELLOW = 2'b11
    } phase_e;

    // Progress through a RED -> GREEN -> YELLOW cycle, built from aligned good reports
    typedef enum logic [1:0] {
        H_NONE = 2'b00,
        H_RED  = 2'b01,
        H_RG   = 2'b10
    } hist_e;

    // OFF is a producer reset, so entering or leaving it is always allowed
    function automatic logic is_legal(input logic [1:0] from_ph, input logic [1:0] to_ph);
        logic ok;
        ok = 1'b0;
        if (from_ph == PH_OFF || to_ph == PH_OFF) begin
            ok = 1'b1;
        end else begin
            ok = (from_ph == PH_RED    && to_ph == PH_GREEN)  ||
                 (from_ph == PH_GREEN  && to_ph == PH_YELLOW) ||
                 (from_ph == PH_YELLOW && to_ph == PH_RED);
        end
        return ok;
    endfunction

endpackage

// File: rtl/lamp_sync.sv
// Two-flop synchronizer bank for asynchronous lamp lines.
module lamp_sync #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_s1;
    logic [W-1:0] r_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

// File: rtl/traffic_lamp_monitor.sv
// Decodes the red/green lamp pair into phases, measures and reports each phase,
// and flags illegal ordering and out-of-tolerance or stuck phases.
module traffic_lamp_monitor #(
    parameter int unsigned CNT_W    = traffic_pkg::CNT_W_DEF,
    parameter int unsigned T_RED    = traffic_pkg::T_RED,
    parameter int unsigned T_GREEN  = traffic_pkg::T_GREEN,
    parameter int unsigned T_YELLOW = traffic_pkg::T_YELLOW,
    parameter int unsigned TOL      = traffic_pkg::T_TOL
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             led_r_in,
    input  logic             led_g_in,
    input  logic             clr_err,
    output logic [1:0]       phase,
    output logic             phase_valid,
    output logic [1:0]       rpt_phase,
    output logic [CNT_W-1:0] rpt_len,
    output logic             rpt_ok,
    output logic             seq_err,
    output logic             dur_err,
    output logic [15:0]      cycles_done
);

    import traffic_pkg::*;

    localparam int unsigned CW1 = CNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       w_code;
    phase_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_aligned;
    hist_e            r_hist;
    logic             r_phase_valid;
    logic [1:0]       r_rpt_phase;
    logic [CNT_W-1:0] r_rpt_len;
    logic             r_rpt_ok;
    logic             r_seq_err;
    logic             r_dur_err;
    logic [15:0]      r_cycles;

    logic             w_change;
    logic             w_legal;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CW1-1:0]   w_len_ext;
    logic [CW1-1:0]   w_nom;
    logic [CW1-1:0]   w_dev;
    logic             w_ok;
    logic             w_report;
    logic             w_overrun;
    logic             w_seq_set;
    logic             w_dur_set;
    logic             w_cycle_done;

    function automatic logic [CW1-1:0] nominal(input phase_e ph);
        logic [CW1-1:0] n;
        n = '0;
        case (ph)
            ST_RED:    n = CW1'(T_RED);
            ST_GREEN:  n = CW1'(T_GREEN);
            ST_YELLOW: n = CW1'(T_YELLOW);
            default:   n = '0;
        endcase
        return n;
    endfunction

    lamp_sync #(
        .W (2)
    ) u_lamp_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   ({led_g_in, led_r_in}),
        .o_q   (w_code)
    );

    // Phase-length measurement and tolerance check against the phase being left
    always_comb begin
        w_change  = (w_code != r_state);
        w_legal   = is_legal(r_state, w_code);
        w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
        w_len_ext = {1'b0, r_cnt};
        w_nom     = nominal(r_state);
        w_dev     = (w_len_ext >= w_nom) ? (w_len_ext - w_nom) : (w_nom - w_len_ext);
        w_ok      = (w_dev <= CW1'(TOL));
        w_report  = w_change && r_aligned && (r_state != ST_OFF);
        w_overrun = !w_change && r_aligned && (r_state != ST_OFF) &&
                    ({1'b0, w_cnt_inc} == (w_nom + CW1'(TOL) + CW1'(1)));
        w_seq_set = w_change && !w_legal;
        w_dur_set = (w_report && !w_ok) || w_overrun;
        w_cycle_done = w_report && w_ok && w_legal &&
                       (r_state == ST_YELLOW) && (r_hist == H_RG);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_OFF;
            r_cnt         <= '0;
            r_aligned     <= 1'b0;
            r_hist        <= H_NONE;
            r_phase_valid <= 1'b0;
            r_rpt_phase   <= 2'b00;
            r_rpt_len     <= '0;
            r_rpt_ok      <= 1'b0;
            r_seq_err     <= 1'b0;
            r_dur_err     <= 1'b0;
            r_cycles      <= '0;
        end else begin
            r_phase_valid <= w_report;
            if (w_report) begin
                r_rpt_phase <= r_state;
                r_rpt_len   <= r_cnt;
                r_rpt_ok    <= w_ok;
            end

            if (w_change) begin
                r_cnt     <= CNT_W'(1);
                r_state   <= phase_e'(w_code);
                // The first phase after OFF or after a bad transition is partial
                r_aligned <= (r_state != ST_OFF) && (w_code != PH_OFF) && w_legal;
            end else begin
                r_cnt <= w_cnt_inc;
            end

            r_seq_err <= w_seq_set || (r_seq_err && !clr_err);
            r_dur_err <= w_dur_set || (r_dur_err && !clr_err);

            if (w_cycle_done) begin
                r_cycles <= r_cycles + 16'd1;
            end

            // Any error or producer reset breaks the RED -> GREEN -> YELLOW chain
            if (w_seq_set || w_overrun || (w_change && w_code == PH_OFF)) begin
                r_hist <= H_NONE;
            end else if (w_report) begin
                if (!w_ok) begin
                    r_hist <= H_NONE;
                end else begin
                    case (r_state)
                        ST_RED:   r_hist <= H_RED;
                        ST_GREEN: r_hist <= (r_hist == H_RED) ? H_RG : H_NONE;
                        default:  r_hist <= H_NONE;
                    endcase
                end
            end
        end
    end

    assign phase       = w_code;
    assign phase_valid = r_phase_valid;
    assign rpt_phase   = r_rpt_phase;
    assign rpt_len     = r_rpt_len;
    assign rpt_ok      = r_rpt_ok;
    assign seq_err     = r_seq_err;
    assign dur_err     = r_dur_err;
    assign cycles_done = r_cycles;

endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// Directed bench for traffic_lamp_monitor with short nominal timings.
module tb_traffic_lamp_monitor;

    localparam int unsigned CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             led_r_in;
    logic             led_g_in;
    logic             clr_err;
    logic [1:0]       phase;
    logic             phase_valid;
    logic [1:0]       rpt_phase;
    logic [CNT_W-1:0] rpt_len;
    logic             rpt_ok;
    logic             seq_err;
    logic             dur_err;
    logic [15:0]      cycles_done;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [1:0]       ph;
        logic [CNT_W-1:0] len;
        logic             ok;
    } rpt_t;

    typedef struct {
        logic r;
        logic g;
        int   n;
        bit   rep;
        int   len;
        bit   ok;
        bit   e_seq;
        bit   e_dur;
        int   e_cyc;
    } vec_t;

    rpt_t q[$];
    vec_t tbl[14];

    traffic_lamp_monitor #(
        .CNT_W    (CNT_W),
        .T_RED    (10),
        .T_GREEN  (10),
        .T_YELLOW (6),
        .TOL      (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .led_r_in    (led_r_in),
        .led_g_in    (led_g_in),
        .clr_err     (clr_err),
        .phase       (phase),
        .phase_valid (phase_valid),
        .rpt_phase   (rpt_phase),
        .rpt_len     (rpt_len),
        .rpt_ok      (rpt_ok),
        .seq_err     (seq_err),
        .dur_err     (dur_err),
        .cycles_done (cycles_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && phase_valid) begin
            q.push_back('{rpt_phase, rpt_len, rpt_ok});
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic g, input int n);
        @(negedge clk);
        led_r_in = r;
        led_g_in = g;
        repeat (n) @(posedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_phase"}, 32'(phase), 0);
        chk({tag, "_valid"}, 32'(phase_valid), 0);
        chk({tag, "_rpt_phase"}, 32'(rpt_phase), 0);
        chk({tag, "_rpt_len"}, 32'(rpt_len), 0);
        chk({tag, "_rpt_ok"}, 32'(rpt_ok), 0);
        chk({tag, "_seq"}, 32'(seq_err), 0);
        chk({tag, "_dur"}, 32'(dur_err), 0);
        chk({tag, "_cycles"}, 32'(cycles_done), 0);
    endtask

    initial begin
        rpt_t rr;
        rst_n    = 1'b0;
        led_r_in = 1'b0;
        led_g_in = 1'b0;
        clr_err  = 1'b0;

        //         r     g     n   rep len ok    seq   dur   cyc
        tbl[0]  = '{1'b0, 1'b0, 4,  0,  0,  0,    0,    0,    0};
        tbl[1]  = '{1'b1, 1'b0, 10, 0,  0,  0,    0,    0,    0};
        tbl[2]  = '{1'b0, 1'b1, 10, 1,  10, 1,    0,    0,    0};
        tbl[3]  = '{1'b1, 1'b1, 6,  1,  6,  1,    0,    0,    0};
        tbl[4]  = '{1'b1, 1'b0, 10, 1,  10, 1,    0,    0,    0};
        tbl[5]  = '{1'b0, 1'b1, 10, 1,  10, 1,    0,    0,    0};
        tbl[6]  = '{1'b1, 1'b1, 6,  1,  6,  1,    0,    0,    0};
        tbl[7]  = '{1'b1, 1'b0, 10, 1,  10, 1,    0,    0,    1};
        tbl[8]  = '{1'b0, 1'b1, 12, 1,  12, 0,    0,    0,    1};
        tbl[9]  = '{1'b1, 1'b1, 6,  1,  6,  1,    0,    1,    1};
        tbl[10] = '{1'b1, 1'b0, 9,  1,  9,  1,    0,    1,    1};
        tbl[11] = '{1'b1, 1'b1, 6,  0,  0,  0,    1,    1,    1};
        tbl[12] = '{1'b1, 1'b0, 10, 1,  10, 1,    1,    1,    1};
        tbl[13] = '{1'b0, 1'b1, 10, 0,  0,  0,    1,    1,    1};

        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Phase sequence: flags and cycle count are as seen at the end of each entry,
        // the report checked is the one for the previous entry
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].r, tbl[i].g, tbl[i].n);
            #1;
            chk($sformatf("v%0d_phase", i), 32'(phase), 32'({tbl[i].g, tbl[i].r}));
            if (i > 0) begin
                if (tbl[i-1].rep) begin
                    if (q.size() == 0) begin
                        n_checks++;
                        n_err++;
                        $display("FAIL v%0d_rpt: got no report expected one", i);
                    end else begin
                        rr = q.pop_front();
                        chk($sformatf("v%0d_rpt_phase", i), 32'(rr.ph), 32'({tbl[i-1].g, tbl[i-1].r}));
                        chk($sformatf("v%0d_rpt_len", i), 32'(rr.len), 32'(tbl[i-1].len));
                        chk($sformatf("v%0d_rpt_ok", i), 32'(rr.ok), 32'(tbl[i-1].ok));
                    end
                end
                chk($sformatf("v%0d_extra_rpt", i), 32'(q.size()), 0);
            end
            chk($sformatf("v%0d_seq", i), 32'(seq_err), 32'(tbl[i].e_seq));
            chk($sformatf("v%0d_dur", i), 32'(dur_err), 32'(tbl[i].e_dur));
            chk($sformatf("v%0d_cyc", i), 32'(cycles_done), 32'(tbl[i].e_cyc));
        end

        // Clear both flags, then clear coincident with overrun at count 12 of aligned GREEN
        @(negedge clk);
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        chk("clr_seq", 32'(seq_err), 0);
        chk("clr_dur", 32'(dur_err), 0);
        @(negedge clk);
        clr_err = 1'b0;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("pre_overrun_dur", 32'(dur_err), 0);
        @(negedge clk);
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        chk("overrun_vs_clr_dur", 32'(dur_err), 1);
        chk("overrun_vs_clr_seq", 32'(seq_err), 0);
        @(negedge clk);
        clr_err = 1'b0;

        // Reset pulse in the middle of an aligned GREEN
        drive(1'b1, 1'b1, 6);
        drive(1'b1, 1'b0, 10);
        drive(1'b0, 1'b1, 7);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        repeat (8) @(posedge clk);
        drive(1'b1, 1'b1, 6);
        #1;
        chk("post_rst_phase", 32'(phase), 3);
        chk("post_rst_no_green_rpt", 32'(q.size()), 0);

        // Latency of a single red-line change from aligned GREEN to YELLOW
        drive(1'b1, 1'b0, 10);
        drive(1'b0, 1'b1, 10);
        @(negedge clk);
        led_r_in = 1'b1;
        @(posedge clk);
        #1;
        chk("lat_e0_phase", 32'(phase), 2);
        chk("lat_e0_valid", 32'(phase_valid), 0);
        @(posedge clk);
        #1;
        chk("lat_e1_phase", 32'(phase), 3);
        chk("lat_e1_valid", 32'(phase_valid), 0);
        @(posedge clk);
        #1;
        chk("lat_e2_valid", 32'(phase_valid), 1);
        chk("lat_e2_rpt_phase", 32'(rpt_phase), 2);
        chk("lat_e2_rpt_len", 32'(rpt_len), 10);
        chk("lat_e2_rpt_ok", 32'(rpt_ok), 1);
        @(posedge clk);
        #1;
        chk("lat_e3_valid", 32'(phase_valid), 0);
        chk("lat_seq", 32'(seq_err), 0);
        chk("lat_dur", 32'(dur_err), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/traffic_lamp_monitor.md
Name: traffic_lamp_monitor

Overview:
Observes the red/green lamp pair driven by the traffic-light sequencer and decodes it back into phases: RED, GREEN, YELLOW (both lamps on) and OFF. Measures each phase's length in clock cycles and emits one report per completed phase. Checks the phase order and each phase length against nominal timing, and holds sticky error flags for the board LEDs. It sits on the same clock as the sequencer and takes the lamp lines as untrusted asynchronous inputs.

Parameters:
CNT_W, 32, width of the phase-length counter and report
T_RED, 625000000, nominal RED length in cycles
T_GREEN, 625000000, nominal GREEN length in cycles
T_YELLOW, 375000000, nominal YELLOW length in cycles
TOL, 2, allowed absolute deviation in cycles, in either direction

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
led_r_in  in  1  red lamp line, asynchronous
led_g_in  in  1  green lamp line, asynchronous
clr_err  in  1  synchronous clear of the sticky flags
phase  out  2  current decoded phase {g,r}: 00 OFF, 01 RED, 10 GREEN, 11 YELLOW
phase_valid  out  1  one-cycle pulse; a completed phase report is on rpt_*
rpt_phase  out  2  phase being reported
rpt_len  out  CNT_W  measured length of that phase in cycles
rpt_ok  out  1  |rpt_len - nominal| <= TOL
seq_err  out  1  sticky: illegal phase transition seen
dur_err  out  1  sticky: phase length out of tolerance, or overrun
cycles_done  out  16  count of full RED->GREEN->YELLOW cycles; wraps at 65535->0

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: phase=00, phase_valid=0, rpt_*=0, seq_err=0, dur_err=0, cycles_done=0, counter=0, synchronizer flops=0, aligned=0.
- Input sync: 2-flop synchronizer per lamp line. The code {g,r} used internally is the stage-2 output.
- States: OFF, RED, GREEN, YELLOW. The state equals the synced code.
- Counter:
  - Loads 1 on the first cycle the code differs from the state.
  - Increments while the code holds.
  - Saturates at all-ones.
  - A producer holding a phase for exactly N cycles yields rpt_len=N.
- aligned flag:
  - Set on any legal transition.
  - Cleared on entry to OFF, on reset, and on an illegal transition.
  - The first phase entered after OFF or after an illegal transition is partial.
- Legal transitions: RED->GREEN, GREEN->YELLOW, YELLOW->RED, any->OFF, OFF->any.
- On a code change out of X (X != OFF), registered on the edge after the synced change:
  - If X was aligned: phase_valid=1 for one cycle, rpt_phase=X, rpt_len=counter, rpt_ok computed.
  - If rpt_ok=0, set dur_err.
  - A partial X produces no report.
- Illegal transition (e.g. RED->YELLOW, GREEN->RED): set seq_err; the aligned report for the old phase is still emitted; the state follows the new code.
- Leaving to OFF is not an error: it represents a producer reset.
- Overrun: while aligned in X, when the counter reaches nominal(X)+TOL+1, set dur_err that cycle. This catches a stuck lamp before the phase ends.
- cycles_done increments when an aligned YELLOW completes and the previous aligned reports were RED then GREEN, with no error in between.
- Latency: an input change before edge E0 is synced at E1. phase updates at E1's output, and phase_valid is high in the cycle after E2.
- clr_err: clears seq_err and dur_err. If a new error is detected in the same cycle, the set wins.
- rst_n asserted mid-phase: everything returns immediately to reset values, and the next phase observed is partial.
- Deviation arithmetic: CNT_W+1 bits, unsigned, no wrap.

Decomposition:
- Shared package traffic_pkg:
  - phase code localparams PH_OFF=2'b00, PH_RED=2'b01, PH_GREEN=2'b10, PH_YELLOW=2'b11
  - default timing constants T_RED, T_GREEN, T_YELLOW
  - these are shared with the sequencer
- One sub-module, lamp_sync: a parameterised-width 2-flop synchronizer with async active-low reset.
- The FSM, counter and checks stay in the top module.

Test Plan:
All scenarios use T_RED=10, T_GREEN=10, T_YELLOW=6, TOL=1.
1. Reset, then drive OFF, then RED 10, GREEN 10, YELLOW 6, RED 10, GREEN 10, YELLOW 6, RED -> RED partial, no report. Then reports GREEN/10/ok, YELLOW/6/ok, RED/10/ok, GREEN/10/ok, YELLOW/6/ok. cycles_done=1, no errors.
2. Aligned GREEN held 12 -> at count 12 dur_err rises (overrun). The report shows rpt_len=12, rpt_ok=0.
3. Aligned RED 9, then YELLOW -> report RED/9/ok, seq_err=1. The following YELLOW is partial, with no report.
4. Pulse clr_err while both flags are set -> both flags 0 next cycle. clr_err coincident with an overrun detection -> dur_err stays 1.
5. Drop rst_n for 1 cycle mid-GREEN (count 5) -> all outputs return to reset values asynchronously. The next GREEN->YELLOW change yields no GREEN report.
6. Lamp change on led_r_in before edge E0 -> phase changes after E1, phase_valid is high in the cycle after E2, and stays high exactly one cycle.
